mouse_digit_formatter: RTL and testbench
========================================

Name: mouse_digit_formatter

Overview:
- Formats mouse coordinates into the four 5-bit digit codes consumed by the 7-segment display driver.
- Each digit code is {dot, 4-bit hex value}.
- Sits between the mouse transceiver, which supplies X/Y bytes and a one-cycle valid strobe, and the display driver.
- Supports two modes:
  - Hex mode: both coordinates shown.
  - Decimal mode: one selected coordinate, converted by a sequential shift-add-3 (double-dabble) engine.

Parameters:
- CONV_STEPS, 8, number of double-dabble shift iterations; equals the coordinate width. Fixed at 8 for this design.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- X_POS  input  8  mouse X coordinate
- Y_POS  input  8  mouse Y coordinate
- DATA_VALID  input  1  one-cycle strobe; X_POS/Y_POS are valid this cycle
- DEC_MODE  input  1  0 = hex display, 1 = decimal display
- SEL_Y  input  1  decimal mode only: 0 shows X, 1 shows Y
- DIGIT_A  output  5  digit position 0 (rightmost), {dot, value}
- DIGIT_B  output  5  digit position 1
- DIGIT_C  output  5  digit position 2
- DIGIT_D  output  5  digit position 3 (leftmost)
- BUSY  output  1  high while a render is in progress

Behaviour:
- Reset (synchronous, active-high, sampled on CLK rising edge):
  - DIGIT_A..D = 5'b00000.
  - BUSY = 0, state = IDLE.
  - Held X/Y = 0, pending flag = 0.
  - Registered mode copies (prev_dec, prev_sel) = 0.
  - RESET dominates all other inputs and aborts any render in progress.
- State IDLE, start condition: DATA_VALID, or pending set, or (DEC_MODE != prev_dec), or (SEL_Y != prev_sel).
- On the start edge k:
  - Capture the coordinates into held regs. DATA_VALID takes priority over pending values. With no new data, held values are reused.
  - Latch DEC_MODE and SEL_Y into prev_dec and prev_sel. Clear pending.
  - Next state: CONV if DEC_MODE=1, else UPDATE.
  - Load shift register = {12'b0, selected coordinate}; step counter = 0.
- State CONV:
  - Each edge: every BCD nibble >= 5 gets +3, then the whole 20-bit register shifts left by 1; counter += 1.
  - After CONV_STEPS edges (k+1..k+8), go to UPDATE.
- State UPDATE: one edge writes all four outputs atomically, then returns to IDLE.
  - Decimal mode: outputs change at edge k+9.
  - Hex mode: outputs change at edge k+1.
- BUSY = 1 in CONV and UPDATE, 0 in IDLE.
- Output mapping, hex mode:
  - D = {0, X[7:4]}
  - C = {1, X[3:0]} (dot separates X from Y)
  - B = {0, Y[7:4]}
  - A = {0, Y[3:0]}
- Output mapping, decimal mode:
  - D = {SEL_Y, 4'h0} (dot marks Y)
  - C = {0, hundreds}, B = {0, tens}, A = {0, ones}
  - Leading zeros are shown. Range is 000..255; BCD nibbles are never >9.
- DATA_VALID while BUSY:
  - Store X/Y into pending regs and set pending. A later strobe overwrites, so only the latest value is kept.
  - The render in progress is unaffected.
  - Pending data starts a new render on the first IDLE cycle.
- DEC_MODE/SEL_Y change while BUSY: no effect mid-render. The mismatch with prev_dec/prev_sel is detected in IDLE and triggers a re-render of the held values.
- Outputs hold their last value between renders. No intermediate BCD value is ever visible on the outputs.

Test Plan:
- Reset then DEC_MODE=0, DATA_VALID with X=8'hA7, Y=8'h3C:
  - 1 cycle later D=5'h0A, C=5'h17, B=5'h03, A=5'h0C.
  - BUSY high for exactly 1 cycle.
- DEC_MODE=1, SEL_Y=0, DATA_VALID with X=8'd255:
  - BUSY high 9 cycles.
  - At edge k+9: D=5'h00, C=5'h02, B=5'h05, A=5'h05.
  - Outputs unchanged at edges k+1..k+8.
- Held Y=8'd9, toggle SEL_Y 0->1 with no DATA_VALID:
  - Re-render starts automatically.
  - Result D=5'h10, C=5'h00, B=5'h00, A=5'h09.
- During a decimal render, strobe X=8'd100, then X=8'd42:
  - First render completes with the original value.
  - Exactly one further render follows, showing 042 (C=0, B=4, A=2).
  - The value 100 is never displayed.
- Assert RESET at CONV step 4:
  - Next edge: all outputs 0, BUSY=0, state IDLE, pending cleared.
  - A subsequent DATA_VALID renders normally.
- Sweep X over 0..255 in decimal mode and compare with a reference divide-by-10 model. Check the 99->100 and 199->200 boundaries explicitly.

Source files
------------

// File: rtl/mouse_digit_formatter.sv
// mouse_digit_formatter: renders mouse X/Y as four {dot,nibble} digit codes in hex or decimal
module mouse_digit_formatter #(
    parameter int CONV_STEPS = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] X_POS,
    input  logic [7:0] Y_POS,
    input  logic       DATA_VALID,
    input  logic       DEC_MODE,
    input  logic       SEL_Y,
    output logic [4:0] DIGIT_A,
    output logic [4:0] DIGIT_B,
    output logic [4:0] DIGIT_C,
    output logic [4:0] DIGIT_D,
    output logic       BUSY
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
    state_t state, next_state;
    logic [7:0] held_x, held_y, pend_x, pend_y, cap_x, cap_y;
    logic pend, prev_dec, prev_sel, start;
    logic [19:0] sr, adj;
    logic [3:0] cnt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    always_comb begin
        start = DATA_VALID || pend || DEC_MODE != prev_dec || SEL_Y != prev_sel;
        cap_x = DATA_VALID ? X_POS : pend ? pend_x : held_x;
        cap_y = DATA_VALID ? Y_POS : pend ? pend_y : held_y;
        adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
        next_state = state == IDLE ? (start ? (DEC_MODE ? CONV : UPDATE) : IDLE) :
                     state == CONV ? (cnt == 4'(CONV_STEPS - 1) ? UPDATE : CONV) : IDLE;
    end

    always_ff @(posedge CLK) state <= RESET ? IDLE : next_state;

    assign BUSY = state != IDLE;

    // prev_dec/prev_sel double as the mode of the render in flight, so mid-render input changes cannot leak in
    always_ff @(posedge CLK) begin
        if (RESET) begin
            held_x <= '0;
            held_y <= '0;
            pend_x <= '0;
            pend_y <= '0;
            pend <= 1'b0;
            prev_dec <= 1'b0;
            prev_sel <= 1'b0;
            sr <= '0;
            cnt <= '0;
            DIGIT_A <= '0;
            DIGIT_B <= '0;
            DIGIT_C <= '0;
            DIGIT_D <= '0;
        end else begin
            if (state == IDLE && start) begin
                held_x <= cap_x;
                held_y <= cap_y;
                prev_dec <= DEC_MODE;
                prev_sel <= SEL_Y;
                pend <= 1'b0;
                sr <= {12'b0, SEL_Y ? cap_y : cap_x};
                cnt <= '0;
            end else if (state != IDLE && DATA_VALID) begin
                pend <= 1'b1;
                pend_x <= X_POS;
                pend_y <= Y_POS;
            end
            if (state == CONV) begin
                sr <= adj << 1;
                cnt <= cnt + 4'd1;
            end
            if (state == UPDATE) begin
                DIGIT_D <= prev_dec ? {prev_sel, 4'h0} : {1'b0, held_x[7:4]};
                DIGIT_C <= prev_dec ? {1'b0, sr[19:16]} : {1'b1, held_x[3:0]};
                DIGIT_B <= prev_dec ? {1'b0, sr[15:12]} : {1'b0, held_y[7:4]};
                DIGIT_A <= prev_dec ? {1'b0, sr[11:8]} : {1'b0, held_y[3:0]};
            end
        end
    end
endmodule

// File: tb/tb_mouse_digit_formatter.sv
// tb_mouse_digit_formatter: directed bench with a cycle-level behavioural model and literal checks
module tb_mouse_digit_formatter;
    logic CLK = 1'b0, RESET = 1'b1;
    logic [7:0] X_POS = '0, Y_POS = '0;
    logic DATA_VALID = 1'b0, DEC_MODE = 1'b0, SEL_Y = 1'b0;
    logic [4:0] DIGIT_A, DIGIT_B, DIGIT_C, DIGIT_D;
    logic BUSY;
    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    mouse_digit_formatter dut (
        .CLK(CLK), .RESET(RESET), .X_POS(X_POS), .Y_POS(Y_POS), .DATA_VALID(DATA_VALID),
        .DEC_MODE(DEC_MODE), .SEL_Y(SEL_Y), .DIGIT_A(DIGIT_A), .DIGIT_B(DIGIT_B),
        .DIGIT_C(DIGIT_C), .DIGIT_D(DIGIT_D), .BUSY(BUSY)
    );

    function automatic logic [19:0] expect_digits(input logic [7:0] x, input logic [7:0] y, input bit dec, input bit sel);
        int v;
        v = sel ? int'(y) : int'(x);
        if (dec) return {sel, 4'h0, 1'b0, 4'(v / 100), 1'b0, 4'((v / 10) % 10), 1'b0, 4'(v % 10)};
        return {1'b0, x[7:4], 1'b1, x[3:0], 1'b0, y[7:4], 1'b0, y[3:0]};
    endfunction

    // model: a render is a countdown of busy cycles; digits come from plain arithmetic when it ends
    int m_rem = 0;
    bit m_pend = 0, m_dec = 0, m_sel = 0;
    logic [7:0] m_hx = '0, m_hy = '0, m_px = '0, m_py = '0;
    logic [19:0] m_exp = '0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_rem = 0;
            m_pend = 0;
            m_dec = 0;
            m_sel = 0;
            m_hx = '0;
            m_hy = '0;
            m_exp = '0;
        end else if (m_rem > 0) begin
            if (DATA_VALID) begin
                m_pend = 1;
                m_px = X_POS;
                m_py = Y_POS;
            end
            m_rem--;
            if (m_rem == 0) m_exp = expect_digits(m_hx, m_hy, m_dec, m_sel);
        end else if (DATA_VALID || m_pend || DEC_MODE != m_dec || SEL_Y != m_sel) begin
            m_hx = DATA_VALID ? X_POS : m_pend ? m_px : m_hx;
            m_hy = DATA_VALID ? Y_POS : m_pend ? m_py : m_hy;
            m_pend = 0;
            m_dec = DEC_MODE;
            m_sel = SEL_Y;
            m_rem = DEC_MODE ? 9 : 1;
        end
    end

    bit watch = 0, saw100 = 0, prev_busy = 0;
    int renders = 0;

    always @(negedge CLK) begin
        logic exp_busy;
        exp_busy = m_rem > 0;
        checks++;
        if ({DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A, BUSY} !== {m_exp, exp_busy}) begin
            failures++;
            $display("FAIL model t=%0t got digits=%h busy=%b exp digits=%h busy=%b",
                     $time, {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, BUSY, m_exp, exp_busy);
        end
        if (watch) begin
            if (BUSY && !prev_busy) renders++;
            if ({DIGIT_C, DIGIT_B, DIGIT_A} == {5'h01, 5'h00, 5'h00}) saw100 = 1;
        end
        prev_busy = BUSY;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        step(2);
        chk("reset_digits", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, 0);
        chk("reset_busy", BUSY, 0);
        RESET = 0;
        // hex render
        X_POS = 8'hA7; Y_POS = 8'h3C; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        chk("hex_busy", BUSY, 1);
        step;
        chk("hex_digits", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h0A, 5'h17, 5'h03, 5'h0C});
        chk("hex_busy_done", BUSY, 0);
        // decimal 255 with hold check
        DEC_MODE = 1; X_POS = 8'd255; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        for (int i = 1; i <= 8; i++) begin
            step;
            chk("dec_hold", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h0A, 5'h17, 5'h03, 5'h0C});
            chk("dec_busy", BUSY, 1);
        end
        step;
        chk("dec_255", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h00, 5'h02, 5'h05, 5'h05});
        chk("dec_busy_done", BUSY, 0);
        // SEL_Y toggle re-renders held Y
        Y_POS = 8'd9; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(10);
        SEL_Y = 1;
        step(10);
        chk("sel_y_9", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h10, 5'h00, 5'h00, 5'h09});
        // strobes while busy keep only the latest
        watch = 1;
        SEL_Y = 0; X_POS = 8'd7; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(2);
        X_POS = 8'd100; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(2);
        X_POS = 8'd42; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(3);
        chk("first_render_7", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h00, 5'h00, 5'h00, 5'h07});
        step(20);
        chk("pending_42", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h00, 5'h00, 5'h04, 5'h02});
        watch = 0;
        chk("render_count", renders, 2);
        chk("never_100", saw100, 0);
        // reset mid-conversion
        X_POS = 8'd123; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step;
        X_POS = 8'd77; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(2);
        RESET = 1; DEC_MODE = 0;
        step;
        chk("abort_digits", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, 0);
        chk("abort_busy", BUSY, 0);
        RESET = 0;
        step(3);
        chk("no_pending_busy", BUSY, 0);
        chk("no_pending_digits", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, 0);
        DEC_MODE = 1; X_POS = 8'd200; DATA_VALID = 1;
        step;
        DATA_VALID = 0;
        step(9);
        chk("after_reset_200", {DIGIT_D, DIGIT_C, DIGIT_B, DIGIT_A}, {5'h00, 5'h02, 5'h00, 5'h00});
        // full decimal sweep, boundaries pinned by hand
        for (int v = 0; v < 256; v++) begin
            X_POS = 8'(v); DATA_VALID = 1;
            step;
            DATA_VALID = 0;
            step(9);
            if (v == 99) chk("b99", {DIGIT_C, DIGIT_B, DIGIT_A}, {5'h00, 5'h09, 5'h09});
            if (v == 100) chk("b100", {DIGIT_C, DIGIT_B, DIGIT_A}, {5'h01, 5'h00, 5'h00});
            if (v == 199) chk("b199", {DIGIT_C, DIGIT_B, DIGIT_A}, {5'h01, 5'h09, 5'h09});
            if (v == 200) chk("b200", {DIGIT_C, DIGIT_B, DIGIT_A}, {5'h02, 5'h00, 5'h00});
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
